// File: rtl/complex_pkg.sv
// Shared constants and FSM encoding for the complex_cal datapath blocks.
// Saturation limits are derived from the operand width so overridden widths stay consistent.
package complex_pkg;

  localparam int DW    = 8;
  localparam int FRAC  = 7;
  localparam int ACC_W = 2 * DW + 1;

  function automatic int sat_max(input int dw);
    return (1 << (dw - 1)) - 1;
  endfunction

  function automatic int sat_min(input int dw);
    return -(1 << (dw - 1));
  endfunction

  localparam int SAT_MAX = sat_max(DW);
  localparam int SAT_MIN = sat_min(DW);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P_AC = 3'd1,
    P_BD = 3'd2,
    P_AD = 3'd3,
    P_BC = 3'd4
  } state_t;

endpackage

// File: rtl/complex_mul_if.sv
// Operand/result bundle between a source and complex_mul.
// Input side: a transfer happens on a rising edge where mul_din_vld && mul_din_rdy; the source holds vld and operands until then. Output side: mul_dout_vld is a one-cycle strobe with no ready.
interface complex_mul_if #(
  parameter int DW = complex_pkg::DW
);
  logic signed [DW-1:0] re_1;
  logic signed [DW-1:0] im_1;
  logic signed [DW-1:0] re_2;
  logic signed [DW-1:0] im_2;
  logic                 mul_din_vld;
  logic                 mul_din_rdy;
  logic signed [DW-1:0] mul_dout_re;
  logic signed [DW-1:0] mul_dout_im;
  logic                 mul_dout_vld;

  modport master (
    output re_1, im_1, re_2, im_2, mul_din_vld,
    input  mul_din_rdy, mul_dout_re, mul_dout_im, mul_dout_vld
  );

  modport slave (
    input  re_1, im_1, re_2, im_2, mul_din_vld,
    output mul_din_rdy, mul_dout_re, mul_dout_im, mul_dout_vld
  );
endinterface

// File: rtl/complex_sat.sv
// Arithmetic right shift by FRAC (rounds toward -inf) followed by a clamp to the signed DW range.
module complex_sat #(
  parameter int DW   = complex_pkg::DW,
  parameter int FRAC = complex_pkg::FRAC
) (
  input  logic signed [2*DW:0]  i_acc,
  output logic signed [DW-1:0]  o_sat
);
  import complex_pkg::*;

  localparam int                       ACC_W  = 2 * DW + 1;
  localparam logic signed [ACC_W-1:0]  LIM_HI = ACC_W'(sat_max(DW));
  localparam logic signed [ACC_W-1:0]  LIM_LO = ACC_W'(sat_min(DW));

  logic signed [ACC_W-1:0] w_shr;

  assign w_shr = i_acc >>> FRAC;

  always_comb begin
    o_sat = w_shr[DW-1:0];
    if (w_shr > LIM_HI) begin
      o_sat = LIM_HI[DW-1:0];
    end else if (w_shr < LIM_LO) begin
      o_sat = LIM_LO[DW-1:0];
    end
  end

endmodule

// File: rtl/complex_mul.sv
// Iterative complex multiplier: (a+jb)(c+jd) on one shared DWxDW signed multiplier over four cycles,
// saturated Q1.(DW-1) result with a one-cycle valid strobe.
module complex_mul #(
  parameter int DW   = complex_pkg::DW,
  parameter int FRAC = complex_pkg::FRAC
) (
  input  logic          clk,
  input  logic          rst_n,
  complex_mul_if.slave  bus,
  output logic [2:0]    o_state
);
  import complex_pkg::*;

  localparam int ACC_W = 2 * DW + 1;

  state_t r_state;
  state_t w_state_nxt;

  logic signed [DW-1:0]    r_a, r_b, r_c, r_d;
  logic signed [ACC_W-1:0] r_acc_re, r_acc_im;
  logic signed [DW-1:0]    w_m1, w_m2;
  logic signed [2*DW-1:0]  w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_im_sum;
  logic signed [DW-1:0]    w_sat_re, w_sat_im;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.mul_din_vld) w_state_nxt = P_AC;
      P_AC:    w_state_nxt = P_BD;
      P_BD:    w_state_nxt = P_AD;
      P_AD:    w_state_nxt = P_BC;
      P_BC:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The single multiplier's operand pair follows the partial-product schedule.
  always_comb begin
    w_m1 = '0;
    w_m2 = '0;
    case (r_state)
      P_AC:    begin w_m1 = r_a; w_m2 = r_c; end
      P_BD:    begin w_m1 = r_b; w_m2 = r_d; end
      P_AD:    begin w_m1 = r_a; w_m2 = r_d; end
      P_BC:    begin w_m1 = r_b; w_m2 = r_c; end
      default: begin w_m1 = '0;  w_m2 = '0;  end
    endcase
  end

  assign w_prod     = w_m1 * w_m2;
  assign w_prod_ext = {w_prod[2*DW-1], w_prod};
  assign w_im_sum   = r_acc_im + w_prod_ext;

  complex_sat #(.DW(DW), .FRAC(FRAC)) u_sat_re (.i_acc(r_acc_re), .o_sat(w_sat_re));
  complex_sat #(.DW(DW), .FRAC(FRAC)) u_sat_im (.i_acc(w_im_sum), .o_sat(w_sat_im));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a              <= '0;
      r_b              <= '0;
      r_c              <= '0;
      r_d              <= '0;
      r_acc_re         <= '0;
      r_acc_im         <= '0;
      bus.mul_dout_re  <= '0;
      bus.mul_dout_im  <= '0;
      bus.mul_dout_vld <= 1'b0;
    end else begin
      bus.mul_dout_vld <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.mul_din_vld) begin
            r_a <= bus.re_1;
            r_b <= bus.im_1;
            r_c <= bus.re_2;
            r_d <= bus.im_2;
          end
        end
        P_AC: r_acc_re <= w_prod_ext;
        P_BD: r_acc_re <= r_acc_re - w_prod_ext;
        P_AD: r_acc_im <= w_prod_ext;
        P_BC: begin
          bus.mul_dout_re  <= w_sat_re;
          bus.mul_dout_im  <= w_sat_im;
          bus.mul_dout_vld <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.mul_din_rdy = (r_state == IDLE);
  assign o_state         = r_state;

endmodule

// File: tb/tb_complex_mul.sv
// Directed bench for complex_mul: hand-computed vectors, mid-operation reset and a continuous-valid stream.
module tb_complex_mul;

  logic       clk;
  logic       rst_n;
  logic [2:0] st;
  int         n_chk  = 0;
  int         n_pass = 0;

  logic [15:0] exp_q[$];

  complex_mul_if #(.DW(8)) bus ();

  complex_mul #(.DW(8), .FRAC(7)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .o_state (st)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
  endtask

  function automatic int sat8(input int v);
    int s;
    s = v >>> 7;
    if (s > 127) return 127;
    if (s < -128) return -128;
    return s;
  endfunction

  task automatic drive_ops(input int a, input int b, input int c, input int d);
    bus.re_1 = 8'(a);
    bus.im_1 = 8'(b);
    bus.re_2 = 8'(c);
    bus.im_2 = 8'(d);
  endtask

  // One full transaction from an idle DUT; operands are scrambled after accept.
  task automatic do_op(input string tag, input int a, input int b, input int c, input int d,
                       input int er, input int ei);
    @(negedge clk);
    check({tag, ":rdy_idle"}, 32'(bus.mul_din_rdy), 32'd1);
    drive_ops(a, b, c, d);
    bus.mul_din_vld = 1'b1;
    @(negedge clk);
    bus.mul_din_vld = 1'b0;
    drive_ops(~a, ~b, ~c, ~d);
    for (int k = 0; k < 4; k++) begin
      check({tag, ":rdy_busy"}, 32'(bus.mul_din_rdy), 32'd0);
      check({tag, ":vld_busy"}, 32'(bus.mul_dout_vld), 32'd0);
      @(negedge clk);
    end
    check({tag, ":vld"}, 32'(bus.mul_dout_vld), 32'd1);
    check({tag, ":re"}, 32'(bus.mul_dout_re), 32'(er));
    check({tag, ":im"}, 32'(bus.mul_dout_im), 32'(ei));
    check({tag, ":rdy_done"}, 32'(bus.mul_din_rdy), 32'd1);
    @(negedge clk);
    check({tag, ":vld_pulse"}, 32'(bus.mul_dout_vld), 32'd0);
    check({tag, ":re_hold"}, 32'(bus.mul_dout_re), 32'(er));
  endtask

  initial begin
    int m_cnt;
    logic m_vld_exp;
    logic drv_vld;
    logic [15:0] exp_v;
    int a, b, c, d;

    rst_n = 1'b0;
    bus.mul_din_vld = 1'b0;
    drive_ops(0, 0, 0, 0);
    @(negedge clk);
    check("reset:re", 32'(bus.mul_dout_re), 32'd0);
    check("reset:im", 32'(bus.mul_dout_im), 32'd0);
    check("reset:vld", 32'(bus.mul_dout_vld), 32'd0);
    check("reset:rdy", 32'(bus.mul_din_rdy), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("basic",     64,    0,   64,    0,   32,    0);
    do_op("sat_re",  -128,    0, -128,    0,  127,    0);
    do_op("sat_im",  -128, -128, -128, -128,    0,  127);
    do_op("sat_neg", -128,  127,  127,  127, -128,   -1);
    do_op("trunc1",     1,    0,   -1,    0,   -1,    0);
    do_op("trunc2",     1,    1,    1,    1,    0,    0);
    do_op("mixed",    100,  -50,   30,   20,   31,    3);

    // reset while in P_AD
    @(negedge clk);
    drive_ops(127, 0, 127, 0);
    bus.mul_din_vld = 1'b1;
    @(negedge clk);
    bus.mul_din_vld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_rst:state_pad", 32'(st), 32'd3);
    rst_n = 1'b0;
    #1;
    check("mid_rst:re", 32'(bus.mul_dout_re), 32'd0);
    check("mid_rst:im", 32'(bus.mul_dout_im), 32'd0);
    check("mid_rst:vld", 32'(bus.mul_dout_vld), 32'd0);
    check("mid_rst:rdy", 32'(bus.mul_din_rdy), 32'd1);
    check("mid_rst:state", 32'(st), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("mid_rst:no_vld", 32'(bus.mul_dout_vld), 32'd0);
    end
    do_op("post_rst", 64, 32, 64, 64, 16, 48);

    // continuous valid with operands changing every cycle
    m_cnt = 0;
    m_vld_exp = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("stream:vld", 32'(bus.mul_dout_vld), 32'(m_vld_exp));
      if (m_vld_exp) begin
        if (exp_q.size() == 0) begin
          check("stream:exp_q_empty", 32'd1, 32'd0);
        end else begin
          exp_v = exp_q.pop_front();
          check("stream:re", 32'(bus.mul_dout_re), 32'($signed(exp_v[15:8])));
          check("stream:im", 32'(bus.mul_dout_im), 32'($signed(exp_v[7:0])));
        end
      end
      check("stream:rdy", 32'(bus.mul_din_rdy), 32'(m_cnt == 0));
      a = ((i * 37 + 11) % 256) - 128;
      b = ((i * 53 + 90) % 256) - 128;
      c = ((i * 29 + 200) % 256) - 128;
      d = ((i * 71 + 3) % 256) - 128;
      drv_vld = (i < 26);
      drive_ops(a, b, c, d);
      bus.mul_din_vld = drv_vld;
      m_vld_exp = (m_cnt == 1);
      if (m_cnt == 0 && drv_vld) begin
        exp_q.push_back({8'(sat8(a * c - b * d)), 8'(sat8(a * d + b * c))});
        m_cnt = 4;
      end else if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
      end
    end
    check("stream:drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
